// File: rtl/lag_channel_receiver_pkg.sv
// lag_channel_receiver_pkg: shared flit type, default sizing and occupancy-width helper
package lag_channel_receiver_pkg;

    localparam int FLIT_DATA_W           = 16;
    localparam int DEFAULT_NPC           = 1;
    localparam int DEFAULT_DEPTH         = 4;
    localparam int DEFAULT_CREDIT_STAGES = 0;

    typedef struct packed {
        logic                   valid;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 codes.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lag_channel_receiver_if.sv
// lag_channel_receiver_if: link-side flits, consumer handshake and status of one router input port
interface lag_channel_receiver_if
    import lag_channel_receiver_pkg::*;
#(
    parameter int nPC   = DEFAULT_NPC,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CW = occ_width(DEPTH);

    flit_t [nPC-1:0]          flit_in;
    flit_t [nPC-1:0]          flit_out;
    logic  [nPC-1:0]          flit_avail;
    logic  [nPC-1:0]          flit_take;
    logic  [nPC-1:0]          credit_out;
    logic  [nPC-1:0][CW-1:0]  occupancy;
    logic  [nPC-1:0]          overflow_err;

    // Upstream channel plus downstream consumer, seen from outside the receiver.
    modport master (
        output flit_in, flit_take,
        input  flit_out, flit_avail, credit_out, occupancy, overflow_err
    );

    // The receiver itself.
    modport slave (
        input  flit_in, flit_take,
        output flit_out, flit_avail, credit_out, occupancy, overflow_err
    );

endinterface

// File: rtl/lag_channel_receiver_fifo.sv
// lag_channel_receiver_fifo: per-PC first-word-fall-through flit buffer with occupancy and sticky overflow
module lag_channel_receiver_fifo
    import lag_channel_receiver_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = occ_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  flit_t         i_flit,
    input  logic          i_take,
    output flit_t         o_flit,
    output logic          o_avail,
    output logic [CW-1:0] o_occ,
    output logic          o_overflow,
    output logic          o_pop
);
    localparam int AW = $clog2(DEPTH);

    flit_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_occ;
    logic           r_overflow;
    logic           w_full;
    logic           w_push;

    assign w_full     = r_occ == CW'(DEPTH);
    assign o_avail    = r_occ != '0;
    assign o_pop      = i_take & o_avail;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push     = i_flit.valid & (~w_full | o_pop);
    // Storage is never read while empty, so it needs no reset.
    assign o_flit     = o_avail ? r_mem[r_rd_ptr] : '0;
    assign o_occ      = r_occ;
    assign o_overflow = r_overflow;

    // Write accepted flits into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_flit;
    end

    // Advance pointers, track occupancy, latch overflow until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (o_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push & ~o_pop)
                r_occ <= r_occ + CW'(1);
            else if (o_pop & ~w_push)
                r_occ <= r_occ - CW'(1);
            if (i_flit.valid & w_full & ~o_pop)
                r_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/lag_channel_receiver.sv
// lag_channel_receiver: buffers flits per physical channel and returns pipelined credits upstream
module lag_channel_receiver
    import lag_channel_receiver_pkg::*;
#(
    parameter int nPC           = DEFAULT_NPC,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int CREDIT_STAGES = DEFAULT_CREDIT_STAGES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lag_channel_receiver_if.slave   bus
);
    localparam int CW = occ_width(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    flit_t [nPC-1:0]                 w_flit_out;
    logic  [nPC-1:0]                 w_avail;
    logic  [nPC-1:0][CW-1:0]         w_occ;
    logic  [nPC-1:0]                 w_overflow;
    logic  [nPC-1:0]                 w_pop;
    logic  [nPC-1:0][CREDIT_STAGES:0] r_credit;
    logic  [nPC-1:0]                 w_credit;

    for (genvar p = 0; p < nPC; p++) begin : g_pc
        lag_channel_receiver_fifo #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_flit     (bus.flit_in[p]),
            .i_take     (bus.flit_take[p]),
            .o_flit     (w_flit_out[p]),
            .o_avail    (w_avail[p]),
            .o_occ      (w_occ[p]),
            .o_overflow (w_overflow[p]),
            .o_pop      (w_pop[p])
        );
        assign w_credit[p] = r_credit[p][CREDIT_STAGES];
    end

    // Delay each pop through CREDIT_STAGES+1 flops so credits match the forward channel latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credit <= '0;
        end else begin
            for (int p = 0; p < nPC; p++) begin
                r_credit[p][0] <= w_pop[p];
                for (int s = 1; s <= CREDIT_STAGES; s++)
                    r_credit[p][s] <= r_credit[p][s-1];
            end
        end
    end

    assign bus.flit_out     = w_flit_out;
    assign bus.flit_avail   = w_avail;
    assign bus.occupancy    = w_occ;
    assign bus.overflow_err = w_overflow;
    assign bus.credit_out   = w_credit;

endmodule

// File: tb/tb_lag_channel_receiver.sv
// tb_lag_channel_receiver: scenario tasks checked against a queue-based reference model
module tb_lag_channel_receiver;
    import lag_channel_receiver_pkg::*;

    localparam int NPC   = 2;
    localparam int DEPTH = 4;
    localparam int CS    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lag_channel_receiver_if #(.nPC(NPC), .DEPTH(DEPTH)) bus ();

    lag_channel_receiver #(
        .nPC           (NPC),
        .DEPTH         (DEPTH),
        .CREDIT_STAGES (CS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    flit_t          q   [NPC][$];
    int             due [NPC][$];
    logic [NPC-1:0] m_ovf    = '0;
    logic [NPC-1:0] m_credit = '0;
    int             pops         [NPC];
    int             credits_seen [NPC];
    flit_t          idle = '0;

    function automatic flit_t mk(input logic [FLIT_DATA_W-1:0] d);
        flit_t f;
        f.valid = 1'b1;
        f.data  = d;
        return f;
    endfunction

    function automatic flit_t head(input int p);
        return q[p].size() != 0 ? q[p][0] : '0;
    endfunction

    // Drive one cycle, advance the model at the edge, then sample 1 time unit later.
    // Sampling after edge n observes cycle n+1; a take driven in cycle t owes a credit in cycle t+1+CS.
    task automatic tick(input flit_t f0, input flit_t f1, input logic [NPC-1:0] take);
        flit_t f;
        bit    pop;
        bit    full;
        bus.flit_in[0] = f0;
        bus.flit_in[1] = f1;
        bus.flit_take  = take;
        @(posedge clk);
        cyc++;
        for (int p = 0; p < NPC; p++) begin
            f = (p == 0) ? f0 : f1;
            if (!rst_n) begin
                q[p].delete();
                due[p].delete();
                m_ovf[p] = 1'b0;
            end else begin
                pop  = take[p] && q[p].size() != 0;
                full = q[p].size() == DEPTH;
                if (pop) begin
                    void'(q[p].pop_front());
                    due[p].push_back(cyc + CS);
                    pops[p]++;
                end
                if (f.valid) begin
                    if (!full || pop) q[p].push_back(f);
                    else m_ovf[p] = 1'b1;
                end
            end
            m_credit[p] = due[p].size() != 0 && due[p][0] == cyc;
            if (m_credit[p]) void'(due[p].pop_front());
        end
        #1;
        for (int p = 0; p < NPC; p++)
            if (bus.credit_out[p]) credits_seen[p]++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            tick(mk(16'hAAAA), mk(16'hBBBB), 2'b11);
            checks++;
            if ({bus.occupancy, bus.flit_avail, bus.flit_out, bus.credit_out, bus.overflow_err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs occ=%0h avail=%0h out=%0h cr=%0h ovf=%0h expected all 0",
                         bus.occupancy, bus.flit_avail, bus.flit_out, bus.credit_out, bus.overflow_err);
            end
        end
        rst_n = 1'b1;
        tick(idle, idle, '0);
        checks++;
        if (bus.occupancy !== '0 || bus.flit_avail !== '0) begin
            errors++;
            $display("FAIL reset_release occ=%0h avail=%0h expected 0", bus.occupancy, bus.flit_avail);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) tick(mk(16'hA0 + 16'(i)), idle, '0);
        checks++;
        if (bus.occupancy[0] !== 3'd4 || bus.flit_out[0] !== mk(16'hA0) || bus.overflow_err !== 2'b00) begin
            errors++;
            $display("FAIL fill occ=%0d out=%0h ovf=%0b expected 4/%0h/00",
                     bus.occupancy[0], bus.flit_out[0], bus.overflow_err, mk(16'hA0));
        end
        tick(mk(16'hFF), idle, '0);
        checks++;
        if (bus.occupancy[0] !== 3'd4 || bus.flit_out[0] !== mk(16'hA0) || bus.overflow_err !== 2'b01) begin
            errors++;
            $display("FAIL overflow occ=%0d out=%0h ovf=%0b expected 4/%0h/01",
                     bus.occupancy[0], bus.flit_out[0], bus.overflow_err, mk(16'hA0));
        end
    endtask

    task automatic test_full_push_pop();
        tick(mk(16'hA4), idle, 2'b01);
        checks++;
        if (bus.occupancy[0] !== 3'd4 || bus.flit_out[0] !== mk(16'hA1)) begin
            errors++;
            $display("FAIL full_push_pop occ=%0d out=%0h expected 4/%0h",
                     bus.occupancy[0], bus.flit_out[0], mk(16'hA1));
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.flit_out[0] !== mk(16'hA0 + 16'(i)) || bus.flit_avail[0] !== 1'b1) begin
                errors++;
                $display("FAIL drain_order[%0d] out=%0h avail=%0b expected %0h/1",
                         i, bus.flit_out[0], bus.flit_avail[0], mk(16'hA0 + 16'(i)));
            end
            tick(idle, idle, 2'b01);
        end
        checks++;
        if (bus.flit_avail[0] !== 1'b0 || bus.flit_out[0] !== '0 || bus.occupancy[0] !== '0) begin
            errors++;
            $display("FAIL drained avail=%0b out=%0h occ=%0d expected 0/0/0",
                     bus.flit_avail[0], bus.flit_out[0], bus.occupancy[0]);
        end
        repeat (CS + 3) tick(idle, idle, '0);
    endtask

    task automatic test_credit_timing();
        int hi [$];
        int t0;
        tick(mk(16'h1), idle, '0);
        tick(mk(16'h2), idle, '0);
        tick(idle, idle, '0);
        t0 = cyc + 1;
        tick(idle, idle, 2'b01);
        if (bus.credit_out[0]) hi.push_back(cyc + 1);
        tick(idle, idle, 2'b01);
        if (bus.credit_out[0]) hi.push_back(cyc + 1);
        repeat (6) begin
            tick(idle, idle, 2'b01);
            if (bus.credit_out[0]) hi.push_back(cyc + 1);
        end
        checks++;
        if (hi.size() != 2) begin
            errors++;
            $display("FAIL credit_count got=%0d expected 2", hi.size());
        end else begin
            checks++;
            if (hi[0] != t0 + 1 + CS || hi[1] != t0 + 2 + CS) begin
                errors++;
                $display("FAIL credit_cycles got=%0d,%0d expected %0d,%0d",
                         hi[0], hi[1], t0 + 1 + CS, t0 + 2 + CS);
            end
        end
    endtask

    task automatic test_pc_independent();
        for (int i = 0; i < 12; i++) begin
            tick(($urandom_range(0, 1) != 0) ? mk(16'($urandom)) : idle, idle, {1'b0, 1'($urandom)});
            checks++;
            if (bus.occupancy[1] !== '0 || bus.credit_out[1] !== 1'b0 || bus.flit_avail[1] !== 1'b0) begin
                errors++;
                $display("FAIL pc1_quiet occ=%0d cr=%0b avail=%0b expected 0/0/0",
                         bus.occupancy[1], bus.credit_out[1], bus.flit_avail[1]);
            end
            checks++;
            if (bus.occupancy[0] !== 3'(q[0].size()) || bus.flit_out[0] !== head(0)) begin
                errors++;
                $display("FAIL pc0_model occ=%0d out=%0h expected %0d/%0h",
                         bus.occupancy[0], bus.flit_out[0], q[0].size(), head(0));
            end
        end
    endtask

    task automatic test_random();
        int    pushes [NPC];
        flit_t f [NPC];
        logic [NPC-1:0] take;
        rst_n = 1'b0;
        tick(idle, idle, '0);
        rst_n = 1'b1;
        for (int p = 0; p < NPC; p++) begin
            pops[p] = 0;
            credits_seen[p] = 0;
            pushes[p] = 0;
        end
        for (int i = 0; i < 400 + 3 * DEPTH + CS; i++) begin
            for (int p = 0; p < NPC; p++) begin
                f[p] = idle;
                if (i < 400 && DEPTH - pushes[p] + credits_seen[p] > 0 && $urandom_range(0, 2) != 0) begin
                    f[p] = mk(16'($urandom));
                    pushes[p]++;
                end
                take[p] = (i >= 400) ? 1'b1 : 1'($urandom);
            end
            tick(f[0], f[1], take);
            for (int p = 0; p < NPC; p++) begin
                checks++;
                if (bus.occupancy[p] !== 3'(q[p].size()) || bus.flit_out[p] !== head(p)) begin
                    errors++;
                    $display("FAIL rand_data pc%0d cyc%0d occ=%0d out=%0h expected %0d/%0h",
                             p, cyc, bus.occupancy[p], bus.flit_out[p], q[p].size(), head(p));
                end
                checks++;
                if (bus.credit_out[p] !== m_credit[p] || bus.overflow_err[p] !== m_ovf[p]) begin
                    errors++;
                    $display("FAIL rand_credit pc%0d cyc%0d cr=%0b ovf=%0b expected %0b/%0b",
                             p, cyc, bus.credit_out[p], bus.overflow_err[p], m_credit[p], m_ovf[p]);
                end
            end
        end
        for (int p = 0; p < NPC; p++) begin
            checks++;
            if (credits_seen[p] != pops[p] || credits_seen[p] != pushes[p] || bus.overflow_err[p] !== 1'b0) begin
                errors++;
                $display("FAIL credit_balance pc%0d credits=%0d pops=%0d pushes=%0d ovf=%0b expected equal, ovf 0",
                         p, credits_seen[p], pops[p], pushes[p], bus.overflow_err[p]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < DEPTH; i++) tick(mk(16'hC0 + 16'(i)), idle, '0);
        tick(idle, idle, 2'b01);
        checks++;
        if (bus.occupancy[0] !== 3'd3) begin
            errors++;
            $display("FAIL midflight_setup occ=%0d expected 3", bus.occupancy[0]);
        end
        rst_n = 1'b0;
        tick(idle, idle, '0);
        rst_n = 1'b1;
        checks++;
        if (bus.occupancy[0] !== '0 || bus.credit_out[0] !== 1'b0 || bus.flit_avail[0] !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset occ=%0d cr=%0b avail=%0b expected 0/0/0",
                     bus.occupancy[0], bus.credit_out[0], bus.flit_avail[0]);
        end
        repeat (CS + 3) begin
            tick(idle, idle, '0);
            checks++;
            if (bus.credit_out !== '0) begin
                errors++;
                $display("FAIL late_credit cr=%0b expected 0", bus.credit_out);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.flit_in   = '0;
        bus.flit_take = '0;
        test_reset();
        test_fill_overflow();
        test_full_push_pop();
        test_credit_timing();
        test_pc_independent();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
